// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the MII receive framer.
// Pure declarations; no logic, no latency.
// No flow control of its own.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_e;

    typedef struct packed {
        logic [47:0] da;
        logic [47:0] sa;
        logic [15:0] etype;
    } hdr_t;

    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;

    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;

endpackage

// File: rtl/eth_crc32_d4.sv
// Reflected CRC32 advance by one nibble, bit 0 of the nibble first.
// Purely combinational, zero latency.
// No flow control; caller decides when to register the result.
module eth_crc32_d4
    import eth_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nibble,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ nibble[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_rx_framer.sv
// MII nibble receiver: strips preamble/SFD, packs bytes, checks FCS/length/alignment, keeps stats.
// Byte out 1 cycle after its high nibble; frame status 1 cycle after en is first seen low.
// No backpressure: the MII side cannot be stalled, so every output is a pulse or a held register.
module mii_rx_framer
    import eth_rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             io_mii_en,
    input  logic [3:0]       io_mii_dat,
    input  logic             io_stats_clr,
    output logic             io_byte_valid,
    output logic [7:0]       io_byte_data,
    output logic             io_byte_sof,
    output logic             io_frame_done,
    output logic             io_frame_ok,
    output logic [15:0]      io_frame_len,
    output logic [47:0]      io_da,
    output logic [47:0]      io_sa,
    output logic [15:0]      io_etype,
    output logic [CNT_W-1:0] io_ok_cnt,
    output logic [CNT_W-1:0] io_crc_err_cnt,
    output logic [CNT_W-1:0] io_len_err_cnt
);

    localparam logic [15:0]      MIN_L   = 16'(MIN_LEN);
    localparam logic [15:0]      MAX_L   = 16'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    rx_state_e   state_q, state_d;
    logic        phase_q;
    logic [3:0]  lo_q;
    logic [15:0] len_q;
    logic [31:0] crc_q, crc_nxt;
    hdr_t        shadow_q, hdr_q;
    logic [7:0]  byte_w;

    logic        frame_end, drop_end;
    logic        align_bad, len_bad, crc_bad, frame_good;

    eth_crc32_d4 u_crc (
        .crc_in  (crc_q),
        .nibble  (io_mii_dat),
        .crc_out (crc_nxt)
    );

    assign byte_w = {io_mii_dat, lo_q};

    // A dangling low nibble means the frame stopped mid-byte.
    assign align_bad  = phase_q;
    assign len_bad    = align_bad || (len_q < MIN_L) || (len_q > MAX_L);
    assign crc_bad    = (crc_q != CRC32_RESIDUE);
    assign frame_good = frame_end && !len_bad && !crc_bad;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        drop_end  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io_mii_en) begin
                    state_d = (io_mii_dat == NIB_PRE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!io_mii_en) begin
                    state_d = ST_IDLE;
                end else if (io_mii_dat == NIB_SFD) begin
                    state_d = ST_DATA;
                end else if (io_mii_dat != NIB_PRE) begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!io_mii_en) begin
                    state_d   = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            ST_DROP: begin
                if (!io_mii_en) begin
                    state_d  = ST_IDLE;
                    drop_end = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte assembly, CRC and header shadow; per-frame state is rearmed whenever not in DATA.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            phase_q       <= 1'b0;
            lo_q          <= 4'h0;
            len_q         <= 16'h0;
            crc_q         <= CRC32_INIT;
            shadow_q      <= '0;
            io_byte_valid <= 1'b0;
            io_byte_data  <= 8'h0;
            io_byte_sof   <= 1'b0;
        end else begin
            io_byte_valid <= 1'b0;
            io_byte_sof   <= 1'b0;
            if (state_q != ST_DATA || !io_mii_en) begin
                phase_q <= 1'b0;
                len_q   <= 16'h0;
                crc_q   <= CRC32_INIT;
            end else begin
                crc_q   <= crc_nxt;
                phase_q <= ~phase_q;
                if (!phase_q) begin
                    lo_q <= io_mii_dat;
                end else begin
                    io_byte_valid <= 1'b1;
                    io_byte_data  <= byte_w;
                    io_byte_sof   <= (len_q == 16'h0);
                    if (len_q != 16'hFFFF) begin
                        len_q <= len_q + 16'd1;
                    end
                    if (len_q < 16'd6) begin
                        shadow_q.da <= {shadow_q.da[39:0], byte_w};
                    end else if (len_q < 16'd12) begin
                        shadow_q.sa <= {shadow_q.sa[39:0], byte_w};
                    end else if (len_q < 16'd14) begin
                        shadow_q.etype <= {shadow_q.etype[7:0], byte_w};
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            io_frame_done <= 1'b0;
            io_frame_ok   <= 1'b0;
            io_frame_len  <= 16'h0;
            hdr_q         <= '0;
        end else begin
            io_frame_done <= frame_end || drop_end;
            if (frame_end || drop_end) begin
                io_frame_ok  <= frame_good;
                io_frame_len <= len_q;
                if (frame_good) begin
                    hdr_q <= shadow_q;
                end
            end
        end
    end

    assign io_da    = hdr_q.da;
    assign io_sa    = hdr_q.sa;
    assign io_etype = hdr_q.etype;

    // Exactly one counter moves per frame; length-class errors mask a bad FCS.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            io_ok_cnt      <= '0;
            io_crc_err_cnt <= '0;
            io_len_err_cnt <= '0;
        end else if (io_stats_clr) begin
            io_ok_cnt      <= '0;
            io_crc_err_cnt <= '0;
            io_len_err_cnt <= '0;
        end else if (drop_end || (frame_end && len_bad)) begin
            io_len_err_cnt <= io_len_err_cnt + CNT_ONE;
        end else if (frame_end && crc_bad) begin
            io_crc_err_cnt <= io_crc_err_cnt + CNT_ONE;
        end else if (frame_end) begin
            io_ok_cnt <= io_ok_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Scoreboard bench for mii_rx_framer: stimulus queues expected bytes and frame results,
// an independent monitor pops and compares them as the DUT presents outputs.
module tb_mii_rx_framer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        io_mii_en;
    logic [3:0]  io_mii_dat;
    logic        io_stats_clr;
    logic        io_byte_valid;
    logic [7:0]  io_byte_data;
    logic        io_byte_sof;
    logic        io_frame_done;
    logic        io_frame_ok;
    logic [15:0] io_frame_len;
    logic [47:0] io_da, io_sa;
    logic [15:0] io_etype;
    logic [31:0] io_ok_cnt, io_crc_err_cnt, io_len_err_cnt;

    mii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(32)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .io_mii_en      (io_mii_en),
        .io_mii_dat     (io_mii_dat),
        .io_stats_clr   (io_stats_clr),
        .io_byte_valid  (io_byte_valid),
        .io_byte_data   (io_byte_data),
        .io_byte_sof    (io_byte_sof),
        .io_frame_done  (io_frame_done),
        .io_frame_ok    (io_frame_ok),
        .io_frame_len   (io_frame_len),
        .io_da          (io_da),
        .io_sa          (io_sa),
        .io_etype       (io_etype),
        .io_ok_cnt      (io_ok_cnt),
        .io_crc_err_cnt (io_crc_err_cnt),
        .io_len_err_cnt (io_len_err_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        ok;
        logic [15:0] len;
        logic [31:0] okc, crcc, lenc;
        logic [47:0] da, sa;
        logic [15:0] et;
    } exp_t;

    exp_t       fq[$];
    logic [8:0] bq[$];
    logic [7:0] frm[$];
    int         tests = 0;
    int         fails = 0;
    logic [47:0] g_da = '0, g_sa = '0;
    logic [15:0] g_et = '0;

    localparam logic [47:0] DA1 = 48'h00_11_22_33_44_55;
    localparam logic [47:0] SA1 = 48'h66_77_88_99_AA_BB;
    localparam logic [47:0] DA2 = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [47:0] SA2 = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [47:0] DA3 = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SA3 = 48'h12_34_56_78_9A_BC;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // body = bytes from DA up to the end of payload; the FCS adds four more.
    task automatic build(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] et,
                         input int body);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(sa[47-8*i -: 8]);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int i = 14; i < body; i++) frm.push_back(8'((i * 7 + 3) & 255));
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) c = crc_byte(c, frm[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic nib(input logic e, input logic [3:0] d);
        io_mii_en  = e;
        io_mii_dat = d;
        @(posedge clock);
        #1;
    endtask

    task automatic send_pre();
        for (int i = 0; i < 15; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hD);
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            bq.push_back({(i == 0), frm[i]});
            nib(1'b1, frm[i][3:0]);
            nib(1'b1, frm[i][7:4]);
        end
    endtask

    task automatic send_frame(input bit extra_nib, input int gap, input bit clr_at_end);
        send_pre();
        send_bytes(frm.size());
        if (extra_nib) nib(1'b1, 4'h3);
        io_stats_clr = clr_at_end;
        nib(1'b0, 4'h0);
        io_stats_clr = 1'b0;
        for (int i = 1; i < gap; i++) nib(1'b0, 4'h0);
    endtask

    task automatic exp_frame(input logic ok, input int len, input int okc, input int crcc,
                             input int lenc);
        exp_t e;
        e.ok = ok; e.len = 16'(len);
        e.okc = 32'(okc); e.crcc = 32'(crcc); e.lenc = 32'(lenc);
        e.da = g_da; e.sa = g_sa; e.et = g_et;
        fq.push_back(e);
    endtask

    task automatic set_good(input logic [47:0] da, input logic [47:0] sa, input logic [15:0] et);
        g_da = da; g_sa = sa; g_et = et;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [8:0] b;
        forever begin
            @(negedge clock);
            if (resetn === 1'b1 && io_byte_valid) begin
                if (bq.size() == 0) begin
                    chk("unexpected_byte", {55'h0, io_byte_sof, io_byte_data}, 64'h1FF_0000);
                end else begin
                    b = bq.pop_front();
                    chk("byte", {55'h0, io_byte_sof, io_byte_data}, {55'h0, b});
                end
            end
            if (resetn === 1'b1 && io_frame_done) begin
                if (fq.size() == 0) begin
                    chk("unexpected_done", 64'(io_frame_done), 64'h0);
                end else begin
                    e = fq.pop_front();
                    chk("frame_ok",    64'(io_frame_ok),    64'(e.ok));
                    chk("frame_len",   64'(io_frame_len),   64'(e.len));
                    chk("ok_cnt",      64'(io_ok_cnt),      64'(e.okc));
                    chk("crc_err_cnt", 64'(io_crc_err_cnt), 64'(e.crcc));
                    chk("len_err_cnt", 64'(io_len_err_cnt), 64'(e.lenc));
                    chk("da",          64'(io_da),          64'(e.da));
                    chk("sa",          64'(io_sa),          64'(e.sa));
                    chk("etype",       64'(io_etype),       64'(e.et));
                end
            end
        end
    end

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_byte_valid"}, 64'(io_byte_valid), 64'h0);
        chk({tag, "_byte_data"},  64'(io_byte_data),  64'h0);
        chk({tag, "_done"},       64'(io_frame_done), 64'h0);
        chk({tag, "_ok"},         64'(io_frame_ok),   64'h0);
        chk({tag, "_len"},        64'(io_frame_len),  64'h0);
        chk({tag, "_da"},         64'(io_da),         64'h0);
        chk({tag, "_ok_cnt"},     64'(io_ok_cnt),     64'h0);
        chk({tag, "_len_cnt"},    64'(io_len_err_cnt), 64'h0);
    endtask

    initial begin : stim
        resetn = 1'b0; io_mii_en = 1'b0; io_mii_dat = 4'h0; io_stats_clr = 1'b0;
        #12;
        chk_zero_outputs("reset");
        @(posedge clock); #1;
        resetn = 1'b1;
        nib(1'b0, 4'h0); nib(1'b0, 4'h0);

        // Good minimum-size frame.
        build(DA1, SA1, 16'h0800, 60);
        set_good(DA1, SA1, 16'h0800);
        exp_frame(1'b1, 64, 1, 0, 0);
        send_frame(1'b0, 3, 1'b0);

        // Payload bit flip: CRC error, header registers keep the previous good frame.
        build(DA2, SA2, 16'h86DD, 60);
        frm[20] = frm[20] ^ 8'h01;
        exp_frame(1'b0, 64, 1, 1, 0);
        send_frame(1'b0, 3, 1'b0);

        // Runt with valid FCS, then giant one byte over the limit.
        build(DA2, SA2, 16'h0800, 56);
        exp_frame(1'b0, 60, 1, 1, 1);
        send_frame(1'b0, 3, 1'b0);
        build(DA2, SA2, 16'h0800, 1515);
        exp_frame(1'b0, 1519, 1, 1, 2);
        send_frame(1'b0, 3, 1'b0);

        // Odd nibble count after an otherwise good frame.
        build(DA2, SA2, 16'h0800, 60);
        exp_frame(1'b0, 64, 1, 1, 3);
        send_frame(1'b1, 3, 1'b0);

        // Corrupt preamble nibble: dropped, counted once when en falls.
        exp_frame(1'b0, 0, 1, 1, 4);
        nib(1'b1, 4'h5); nib(1'b1, 4'h5); nib(1'b1, 4'h7);
        for (int i = 1; i < 7; i++) nib(1'b1, 4'(i));
        nib(1'b0, 4'h0); nib(1'b0, 4'h0); nib(1'b0, 4'h0);

        // en falls inside the preamble: silent.
        for (int i = 0; i < 5; i++) nib(1'b1, 4'h5);
        for (int i = 0; i < 4; i++) nib(1'b0, 4'h0);
        chk("abort_ok_cnt",  64'(io_ok_cnt),      64'd1);
        chk("abort_crc_cnt", 64'(io_crc_err_cnt), 64'd1);
        chk("abort_len_cnt", 64'(io_len_err_cnt), 64'd4);

        // Standalone clear.
        io_stats_clr = 1'b1;
        nib(1'b0, 4'h0);
        io_stats_clr = 1'b0;
        chk("clr_ok_cnt",  64'(io_ok_cnt),      64'd0);
        chk("clr_crc_cnt", 64'(io_crc_err_cnt), 64'd0);
        chk("clr_len_cnt", 64'(io_len_err_cnt), 64'd0);

        // Back-to-back good frames with a single idle cycle, then clear on the third's end.
        build(DA1, SA1, 16'h0800, 60);
        set_good(DA1, SA1, 16'h0800);
        exp_frame(1'b1, 64, 1, 0, 0);
        send_frame(1'b0, 1, 1'b0);
        build(DA3, SA3, 16'h0806, 100);
        set_good(DA3, SA3, 16'h0806);
        exp_frame(1'b1, 104, 2, 0, 0);
        send_frame(1'b0, 3, 1'b0);
        build(DA1, SA1, 16'h0800, 60);
        set_good(DA1, SA1, 16'h0800);
        exp_frame(1'b1, 64, 0, 0, 0);
        send_frame(1'b0, 3, 1'b1);
        build(DA3, SA3, 16'h88B5, 70);
        set_good(DA3, SA3, 16'h88B5);
        exp_frame(1'b1, 74, 1, 0, 0);
        send_frame(1'b0, 3, 1'b0);

        // Reset 30 bytes into a frame.
        build(DA2, SA2, 16'h0800, 60);
        send_pre();
        send_bytes(30);
        nib(1'b1, frm[30][3:0]);
        io_mii_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        @(posedge clock); #1;
        resetn = 1'b1;
        nib(1'b0, 4'h0); nib(1'b0, 4'h0);
        set_good(DA2, SA2, 16'h0800);
        exp_frame(1'b1, 64, 1, 0, 0);
        send_frame(1'b0, 3, 1'b0);

        for (int i = 0; i < 50 && (fq.size() != 0 || bq.size() != 0); i++) @(negedge clock);
        chk("pending_frames", 64'(fq.size()), 64'd0);
        chk("pending_bytes",  64'(bq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mii_rx_framer.md
Name: mii_rx_framer

Overview:
- Downstream consumer of the packet generator's 4-bit MII stream (tx_en/tx_data).
- Strips preamble/SFD, packs nibbles into bytes, checks FCS with CRC32, length and alignment, and captures the DA/SA/EtherType header.
- Publishes good/bad frame counters for readback over the SPI debug register file.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS inclusive)
- MAX_LEN, 1518, maximum legal frame length in bytes
- CNT_W, 32, width of the statistics counters

Ports:
- clock  in  1  system clock; one MII nibble per cycle while io_mii_en=1
- resetn  in  1  reset
- io_mii_en  in  1  frame-active qualifier
- io_mii_dat  in  4  nibble, low nibble of each byte first
- io_stats_clr  in  1  synchronous clear of all counters
- io_byte_valid  out  1  io_byte_data valid this cycle
- io_byte_data  out  8  assembled post-SFD byte (FCS bytes included)
- io_byte_sof  out  1  marks first byte after SFD
- io_frame_done  out  1  one-cycle pulse at frame end
- io_frame_ok  out  1  frame status, valid with io_frame_done
- io_frame_len  out  16  byte length of the last frame, saturating at 0xFFFF
- io_da  out  48  DA of the last good frame
- io_sa  out  48  SA of the last good frame
- io_etype  out  16  EtherType of the last good frame
- io_ok_cnt  out  CNT_W  count of good frames
- io_crc_err_cnt  out  CNT_W  count of FCS-failed frames
- io_len_err_cnt  out  CNT_W  count of runt, giant, alignment and preamble errors

Interface decision: one clock `clock`; reset `resetn`, asynchronous, active-low.

Behaviour:
- Reset values: all outputs 0. FSM returns to IDLE. CRC register loads 0xFFFFFFFF.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: on en=1, if nibble=0x5 go to PREAMBLE; otherwise go to DROP and flag a preamble error.
  - PREAMBLE: nibble 0x5 stays; nibble 0xD (SFD) goes to DATA; any other nibble goes to DROP with a preamble error; en=0 returns to IDLE silently (no count, no done).
  - DATA: even nibble phase stores the low nibble; odd phase forms the byte {hi,lo}.
  - DATA byte side effects: io_byte_valid pulses the cycle after the high nibble is sampled; the CRC is updated per nibble; length increments per byte.
  - DATA exit: en=0 ends the frame and returns to IDLE.
  - DROP: waits for en=0; then io_frame_done=1, ok=0, io_len_err_cnt+1, and the FSM returns to IDLE.
- Frame end: evaluated in the cycle en is first sampled low. The next cycle gives io_frame_done=1 with io_frame_ok and io_frame_len updated.
- Frame end fail conditions:
  - Odd nibble count gives an alignment error.
  - len<MIN_LEN or len>MAX_LEN gives a length error.
  - CRC residue ≠ 0xDEBB20E3 gives a CRC error.
- Error priority: length/alignment errors take precedence over CRC errors. Exactly one counter increments per frame.
- Header capture: shadow registers load byte indices 0–5 (DA), 6–11 (SA), 12–13 (EtherType), MSB-first in byte order. io_da, io_sa and io_etype are copied from the shadows only when io_frame_ok=1.
- Counters: wrap modulo 2^CNT_W. io_stats_clr wins over a same-cycle increment.
- Back-to-back frames: a single en=0 cycle is a sufficient gap. A new preamble may start the cycle after the done evaluation, and the done pulse still fires.
- Reset mid-frame: immediately abandons the frame with no done pulse; counters clear.
- Giant frames: the length counter saturates. CRC and byte output continue until en=0.

Decomposition:
- Package eth_rx_pkg holds:
  - the FSM state enum
  - CRC32_INIT=32'hFFFFFFFF
  - CRC32_RESIDUE=32'hDEBB20E3
  - CRC32_POLY_REFL=32'hEDB88320
  - NIB_PRE=4'h5 and NIB_SFD=4'hD
- Sub-module eth_crc32_d4: combinational 4-bit reflected CRC32 update (crc_in, nibble -> crc_out). Reused by the CRC checker path.

Test Plan:
- Good 64-byte frame: 15×0x5, 0xD, 60-byte payload (DA=00:11:22:33:44:55, SA=66:77:88:99:AA:BB, etype=0x0800) + correct FCS -> done ok=1, len=64, headers match, ok_cnt=1.
- Same frame with one payload bit flipped -> ok=0, crc_err_cnt=1, io_da unchanged from the previous good value.
- 60-byte frame (runt) with correct FCS -> ok=0, len_err_cnt=1. 1519-byte frame -> len_err_cnt=2.
- en drops after an odd nibble count, and a preamble nibble 0x7 -> each gives one len_err_cnt increment with a done pulse. en dropping during preamble -> no done, no counts.
- Two good frames separated by one en=0 cycle -> two done pulses, ok_cnt=2. Assert io_stats_clr on the second done -> ok_cnt=0.
- resetn asserted at byte 30 of a frame -> all outputs 0 immediately. The next good frame gives ok_cnt=1.
